sram_1rw_arbiter: RTL
=====================

# sram_1rw_arbiter

Two-port round-robin arbiter and sequencer for a single-port 1RW SRAM macro (64x8 by default). It shares the macro between two valid/ready requesters and zero-fills the array after every reset. It also returns read data with a fixed one-cycle latency. It sits directly in front of the macro, and both run on the same clock.

## Interface

Parameters:
- ADDR_W, 6, address width; depth = 2**ADDR_W
- DATA_W, 8, data width

Ports:
- clk  in  1  block clock; also drives the macro CE pin
- rst_n  in  1  asynchronous, active-low reset
- req_valid_0 / req_valid_1  in  1 each  request present
- req_ready_0 / req_ready_1  out  1 each  request accepted this cycle
- req_we_0 / req_we_1  in  1 each  1 = write, 0 = read
- req_addr_0 / req_addr_1  in  ADDR_W each  word address
- req_wdata_0 / req_wdata_1  in  DATA_W each  write data
- rsp_valid_0 / rsp_valid_1  out  1 each  read data valid
- rsp_rdata  out  DATA_W  read data, shared by both ports; qualified by rsp_valid_x
- init_done  out  1  clear sequence finished
- sram_A  out  ADDR_W  macro address
- sram_CSB  out  1  macro chip select, active low
- sram_WEB  out  1  macro write enable, active low
- sram_OEB  out  1  macro output enable, active low
- sram_I  out  DATA_W  macro write data
- sram_O  in  DATA_W  macro read data

## Operation

- FSM states: CLEAR and RUN. Reset enters CLEAR.
- CLEAR:
  - Every cycle: sram_CSB=0, sram_WEB=0, sram_I=0, sram_A=clr_cnt.
  - clr_cnt increments every cycle starting from 0.
  - After the cycle with clr_cnt = 2**ADDR_W-1, the FSM moves to RUN and init_done goes to 1.
  - CLEAR lasts exactly 2**ADDR_W cycles. Both req_ready outputs are 0 throughout.
- RUN arbitration:
  - One request is granted per cycle.
  - If only one port is valid, that port wins.
  - If both are valid, the winner is the port that did not win most recently. The rr pointer resets to "port 0 preferred".
  - The grant is combinational from req_valid_x and the rr pointer only. It has no dependence on req_ready.
  - req_ready_x = grant_x. A transfer is valid & ready.
  - On a transfer:
    - sram_CSB=0, sram_WEB=~req_we_x, sram_A=req_addr_x, sram_I=req_wdata_x.
    - The rr pointer updates at the clock edge.
  - With no transfer: sram_CSB=1, sram_WEB=1, sram_A and sram_I hold their last value (don't-care).
- Reads:
  - A read accepted in cycle t sets the owner flag in a 1-bit pending register.
  - In cycle t+1, rsp_valid_owner=1 for exactly one cycle and rsp_rdata=sram_O.
  - rsp_valid_0 and rsp_valid_1 are never both 1.
- Writes produce no response.
- There is no response backpressure. Requesters must sink data in cycle t+1.
- Requester rules: a requester holds req_valid and its payload stable until it sees ready. The block does not check this.
- Back-to-back ordering:
  - A write in cycle t followed by a read of the same address in t+1 returns the new data.
  - A read in t followed by a write in t+1 returns the old data.
  - No hazard logic is needed because the macro is sequential.
- sram_OEB is 1 while rst_n=0 and in CLEAR, and 0 in RUN.

## Timing

- Reset values (asserted asynchronously):
  - Outputs: init_done=0, rsp_valid_0/1=0, req_ready_0/1=0, sram_CSB=1, sram_WEB=1, sram_OEB=1.
  - Internal state: rr pointer = port 0, clr_cnt=0, pending cleared.
- First cycle after rst_n deasserts: the CLEAR write to address 0.
- The first RUN cycle is cycle 2**ADDR_W after deassertion, i.e. cycle 64 by default. req_ready may be 1 in that cycle.
- Read latency: one cycle from transfer to rsp_valid. Throughput is one request per cycle, mixed freely between ports.
- Reset in mid-operation:
  - Any pending response is dropped; rsp_valid does not fire.
  - The FSM returns to CLEAR, and the array is fully re-zeroed.
  - An in-flight macro access at the reset edge is not guaranteed.
- clr_cnt is ADDR_W bits. The terminal count is detected explicitly, with no wrap-around into a second pass.
- All SRAM control outputs are combinational from registered state plus req inputs. They settle before the same clk edge samples them.

## Test plan

- Reset/clear: release rst_n, hold both req_valid=1 throughout.
  - Required: req_ready stays 0 for cycles 0–63; sram_WEB=0 with sram_A stepping 0→63 and sram_I=0.
  - Required: init_done=1 from cycle 64; a subsequent read of address 37 returns 0x00.
- Single port write/read: port 0 writes 0xA5 to address 5, then reads address 5 on the next cycle.
  - Required: rsp_valid_0=1 exactly one cycle after the read transfer, with rsp_rdata=0xA5; rsp_valid_1 stays 0.
- Contention: both ports hold valid reads for 6 cycles (port 0 → address 1, port 1 → address 2, preloaded with 0x11 and 0x22).
  - Required: grants alternate 0,1,0,1,0,1.
  - Required: responses alternate rsp_valid_0/0x11 and rsp_valid_1/0x22, each one cycle after its grant.
- Ordering hazard, address 9 initially 0x00:
  - Sequence: read in t, write 0x3C in t+1, read in t+2.
  - Required: responses 0x00 at t+1 and 0x3C at t+3.
- Reset in mid-stream: assert rst_n low in the cycle after a read transfer.
  - Required: no rsp_valid pulse for that read; outputs at their reset values immediately (asynchronously).
  - Required: a full 64-cycle CLEAR follows, after which the previously written address reads 0x00.
- Idle: no valid for 10 cycles in RUN.
  - Required: sram_CSB=1 and both rsp_valid=0 throughout; the rr pointer is unchanged, so the next contention grants the port that did not win last.

Source files
------------

// File: rtl/sram_1rw_arbiter.sv
// Round-robin arbiter and sequencer in front of a single-port 1RW SRAM macro.
// Zero-fills the whole array after every reset, then shares the macro between
// two valid/ready requesters and returns read data one cycle after acceptance.
module sram_1rw_arbiter #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_0,
  input  logic              req_valid_1,
  output logic              req_ready_0,
  output logic              req_ready_1,
  input  logic              req_we_0,
  input  logic              req_we_1,
  input  logic [ADDR_W-1:0] req_addr_0,
  input  logic [ADDR_W-1:0] req_addr_1,
  input  logic [DATA_W-1:0] req_wdata_0,
  input  logic [DATA_W-1:0] req_wdata_1,
  output logic              rsp_valid_0,
  output logic              rsp_valid_1,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              init_done,
  output logic [ADDR_W-1:0] sram_A,
  output logic              sram_CSB,
  output logic              sram_WEB,
  output logic              sram_OEB,
  output logic [DATA_W-1:0] sram_I,
  input  logic [DATA_W-1:0] sram_O
);

  typedef enum logic [0:0] {StClear, StRun} state_t;

  localparam logic [ADDR_W-1:0] ClrLast = '1;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
  // rr_q = 0: port 0 preferred on contention; 1: port 1 preferred.
  logic                rr_q, rr_d;
  logic                pend_q, pend_d;
  logic                owner_q, owner_d;
  logic [ADDR_W-1:0]   a_q, a_c;
  logic [DATA_W-1:0]   i_q, i_c;
  logic                csb_c, web_c;
  logic                run;
  logic                grant_0, grant_1;

  assign run = (state_q == StRun);

  // Grant depends only on valids and the rr pointer, never on ready.
  always_comb begin
    grant_0 = run & req_valid_0 & (~req_valid_1 | ~rr_q);
    grant_1 = run & req_valid_1 & (~req_valid_0 | rr_q);
  end

  // Next-state logic and macro control for the clear and run phases.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    rr_d      = rr_q;
    pend_d    = 1'b0;
    owner_d   = owner_q;
    csb_c     = 1'b1;
    web_c     = 1'b1;
    a_c       = a_q;
    i_c       = i_q;
    unique case (state_q)
      StClear: begin
        csb_c = 1'b0;
        web_c = 1'b0;
        a_c   = clr_cnt_q;
        i_c   = '0;
        // Explicit terminal count: leave after the last address, no second pass.
        if (clr_cnt_q == ClrLast) begin
          state_d   = StRun;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      StRun: begin
        if (grant_0) begin
          csb_c   = 1'b0;
          web_c   = ~req_we_0;
          a_c     = req_addr_0;
          i_c     = req_wdata_0;
          rr_d    = 1'b1;
          pend_d  = ~req_we_0;
          owner_d = 1'b0;
        end else if (grant_1) begin
          csb_c   = 1'b0;
          web_c   = ~req_we_1;
          a_c     = req_addr_1;
          i_c     = req_wdata_1;
          rr_d    = 1'b0;
          pend_d  = ~req_we_1;
          owner_d = 1'b1;
        end
      end
      default: state_d = StClear;
    endcase
  end

  // State, counters, rr pointer, read-pending flag and held macro bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StClear;
      clr_cnt_q <= '0;
      rr_q      <= 1'b0;
      pend_q    <= 1'b0;
      owner_q   <= 1'b0;
      a_q       <= '0;
      i_q       <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      rr_q      <= rr_d;
      pend_q    <= pend_d;
      owner_q   <= owner_d;
      a_q       <= a_c;
      i_q       <= i_c;
    end
  end

  // Outputs; reset forces the macro idle even though the FSM sits in clear.
  always_comb begin
    req_ready_0 = grant_0;
    req_ready_1 = grant_1;
    rsp_valid_0 = pend_q & ~owner_q;
    rsp_valid_1 = pend_q & owner_q;
    rsp_rdata   = sram_O;
    init_done   = run;
    sram_A      = a_c;
    sram_I      = i_c;
    sram_CSB    = rst_n ? csb_c : 1'b1;
    sram_WEB    = rst_n ? web_c : 1'b1;
    sram_OEB    = ~run;
  end

endmodule
